// File: rtl/aplic_idc_if.sv
// Notifier <-> gateway/hart bundle for one APLIC domain and one IDC.
// slave = notifier side, master = gateway/hart side.
interface aplic_idc_if #(
    parameter int NR_SRC   = 32,
    parameter int IPRIOLEN = 3
);
    localparam int NR_BITS_SRC = (NR_SRC > 32) ? 32 : NR_SRC;
    localparam int NR_REG      = (NR_SRC - 1) / 32;
    localparam int ID_W        = $clog2(NR_SRC);

    logic [NR_REG:0][NR_BITS_SRC-1:0] i_intp_pen;
    logic [NR_REG:0][NR_BITS_SRC-1:0] i_enabled;
    logic [NR_SRC-1:1][IPRIOLEN-1:0]  i_target_prio;
    logic                             i_domaincfgIE;
    logic                             i_idelivery;
    logic [IPRIOLEN-1:0]              i_ithreshold;
    logic                             i_claim;
    logic [ID_W-1:0]                  o_topi_id;
    logic [IPRIOLEN-1:0]              o_topi_prio;
    logic                             o_irq;
    logic [NR_REG:0][NR_BITS_SRC-1:0] o_claimed;

    modport master (
        output i_intp_pen, i_enabled, i_target_prio, i_domaincfgIE, i_idelivery,
               i_ithreshold, i_claim,
        input  o_topi_id, o_topi_prio, o_irq, o_claimed
    );

    modport slave (
        input  i_intp_pen, i_enabled, i_target_prio, i_domaincfgIE, i_idelivery,
               i_ithreshold, i_claim,
        output o_topi_id, o_topi_prio, o_irq, o_claimed
    );
endinterface

// File: rtl/aplic_idc_notifier.sv
// Purpose: scans one source per cycle for the best pending+enabled IRQ, commits topi, issues claim pulses.
// Latency: one pass is NR_SRC-1 scan cycles + 1 commit cycle; input changes reach topi within two passes.
// Backpressure: none; claims are accepted every cycle except the CLAIM_WAIT cycle, which ignores them.
module aplic_idc_notifier #(
    parameter int NR_SRC   = 32,
    parameter int IPRIOLEN = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    aplic_idc_if.slave  bus
);
    localparam int NR_BITS_SRC = (NR_SRC > 32) ? 32 : NR_SRC;
    localparam int NR_REG      = (NR_SRC - 1) / 32;
    localparam int ID_W        = $clog2(NR_SRC);
    localparam int VEC_W       = (NR_REG + 1) * NR_BITS_SRC;
    localparam logic [ID_W-1:0] FIRST_IDX = ID_W'(1);
    localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NR_SRC - 1);

    typedef enum logic [1:0] {SCAN, COMMIT, CLAIM_WAIT} state_t;

    state_t              state, state_nxt;
    logic [ID_W-1:0]     idx, best_id, topi_id;
    logic [IPRIOLEN-1:0] best_prio, topi_prio, cand_prio;
    logic [VEC_W-1:0]    pen_flat, en_flat, claimed, claimed_nxt;
    logic                cand_hit, cand_better, commit_ok, claim_take;
    logic                unused_bit0;

    assign pen_flat    = bus.i_intp_pen;
    assign en_flat     = bus.i_enabled;
    assign unused_bit0 = pen_flat[0] ^ en_flat[0];

    // Candidate mux; a programmed priority of 0 ranks as 1.
    always_comb begin
        cand_hit  = 1'b0;
        cand_prio = '0;
        for (int i = 1; i < NR_SRC; i++) begin
            if (idx == ID_W'(i)) begin
                cand_hit  = pen_flat[i] & en_flat[i];
                cand_prio = (bus.i_target_prio[i] == '0) ? IPRIOLEN'(1) : bus.i_target_prio[i];
            end
        end
    end

    always_comb begin
        claimed_nxt = '0;
        for (int i = 1; i < NR_SRC; i++) begin
            claimed_nxt[i] = (topi_id == ID_W'(i));
        end
    end

    // Strict compare keeps the lower id on priority ties.
    assign cand_better = cand_hit && ((best_id == '0) || (cand_prio < best_prio));
    assign commit_ok   = (best_id != '0) &&
                         ((bus.i_ithreshold == '0) || (best_prio < bus.i_ithreshold));
    assign claim_take  = bus.i_claim && (topi_id != '0) && (state != CLAIM_WAIT);

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= SCAN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (claim_take) begin
            state_nxt = CLAIM_WAIT;
        end else begin
            case (state)
                SCAN:       if (idx == LAST_IDX) state_nxt = COMMIT;
                COMMIT:     state_nxt = SCAN;
                CLAIM_WAIT: state_nxt = SCAN;
                default:    state_nxt = SCAN;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx       <= FIRST_IDX;
            best_id   <= '0;
            best_prio <= '1;
            topi_id   <= '0;
            topi_prio <= '0;
            claimed   <= '0;
        end else begin
            claimed <= '0;
            if (claim_take) begin
                // Any partial pass may still hold the claimed source, so restart it.
                claimed   <= claimed_nxt;
                topi_id   <= '0;
                topi_prio <= '0;
                idx       <= FIRST_IDX;
                best_id   <= '0;
                best_prio <= '1;
            end else begin
                case (state)
                    SCAN: begin
                        if (cand_better) begin
                            best_id   <= idx;
                            best_prio <= cand_prio;
                        end
                        idx <= idx + ID_W'(1);
                    end
                    COMMIT: begin
                        topi_id   <= commit_ok ? best_id   : '0;
                        topi_prio <= commit_ok ? best_prio : '0;
                        idx       <= FIRST_IDX;
                        best_id   <= '0;
                        best_prio <= '1;
                    end
                    default: begin
                        idx       <= FIRST_IDX;
                        best_id   <= '0;
                        best_prio <= '1;
                    end
                endcase
            end
        end
    end

    assign bus.o_topi_id   = topi_id;
    assign bus.o_topi_prio = topi_prio;
    assign bus.o_claimed   = claimed;
    assign bus.o_irq       = bus.i_domaincfgIE & bus.i_idelivery & (topi_id != '0);
endmodule

// File: tb/tb_aplic_idc_notifier.sv
// Directed bench for aplic_idc_notifier (NR_SRC=32, IPRIOLEN=3); the bench models the gateway by hand.
module tb_aplic_idc_notifier;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   bad;

    always #5 clk = ~clk;

    aplic_idc_if #(.NR_SRC(32), .IPRIOLEN(3)) bus ();

    aplic_idc_notifier #(.NR_SRC(32), .IPRIOLEN(3)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int id, input logic [2:0] p, input logic on);
        bus.i_intp_pen[0][id] = on;
        bus.i_enabled[0][id]  = on;
        bus.i_target_prio[id] = p;
    endtask

    task automatic wait_topi(input logic [4:0] id, input int budget);
        int n = 0;
        while (bus.o_topi_id !== id && n < budget) begin
            tick(1);
            n++;
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus.i_intp_pen    = '0;
        bus.i_enabled     = '0;
        bus.i_target_prio = '1;
        bus.i_domaincfgIE = 1'b0;
        bus.i_idelivery   = 1'b0;
        bus.i_ithreshold  = '0;
        bus.i_claim       = 1'b0;
        tick(3);
        rst = 1'b0;

        // Reset state and quiet idle
        check("rst_topi_id",   bus.o_topi_id,   0);
        check("rst_topi_prio", bus.o_topi_prio, 0);
        check("rst_irq",       bus.o_irq,       0);
        check("rst_claimed",   bus.o_claimed,   0);
        bad = 0;
        repeat (200) begin
            tick(1);
            if (bus.o_topi_id != 0 || bus.o_irq != 0 || bus.o_claimed != 0) bad++;
        end
        check("idle_200", bad, 0);

        // Best of src5/prio4 and src9/prio2
        bus.i_domaincfgIE = 1'b1;
        bus.i_idelivery   = 1'b1;
        set_src(5, 3'd4, 1'b1);
        set_src(9, 3'd2, 1'b1);
        wait_topi(5'd9, 64);
        check("best_id",   bus.o_topi_id,   9);
        check("best_prio", bus.o_topi_prio, 2);
        check("best_irq",  bus.o_irq,       1);
        bus.i_domaincfgIE = 1'b0;
        #1 check("irq_ie_off", bus.o_irq, 0);
        bus.i_domaincfgIE = 1'b1;
        bus.i_idelivery   = 1'b0;
        #1 check("irq_idel_off", bus.o_irq, 0);
        bus.i_idelivery = 1'b1;

        // Tie keeps lower id; prio field 0 ranks as 1
        set_src(5, 3'd7, 1'b0);
        set_src(9, 3'd7, 1'b0);
        set_src(3, 3'd2, 1'b1);
        set_src(7, 3'd2, 1'b1);
        wait_topi(5'd3, 64);
        check("tie_id",   bus.o_topi_id,   3);
        check("tie_prio", bus.o_topi_prio, 2);
        set_src(12, 3'd0, 1'b1);
        wait_topi(5'd12, 64);
        check("prio0_id",   bus.o_topi_id,   12);
        check("prio0_prio", bus.o_topi_prio, 1);
        set_src(12, 3'd7, 1'b0);
        set_src(3, 3'd7, 1'b0);
        set_src(7, 3'd7, 1'b0);

        // Threshold
        set_src(5, 3'd4, 1'b1);
        set_src(9, 3'd2, 1'b1);
        wait_topi(5'd9, 64);
        check("thr_pre_id", bus.o_topi_id, 9);
        bus.i_ithreshold = 3'd2;
        tick(64);
        check("thr2_id",   bus.o_topi_id,   0);
        check("thr2_prio", bus.o_topi_prio, 0);
        check("thr2_irq",  bus.o_irq,       0);
        bus.i_ithreshold = 3'd3;
        wait_topi(5'd9, 64);
        check("thr3_id",   bus.o_topi_id,   9);
        check("thr3_prio", bus.o_topi_prio, 2);
        bus.i_ithreshold = 3'd0;

        // Claim of src9, then gateway drops its pending bit
        bus.i_claim = 1'b1;
        tick(1);
        bus.i_claim = 1'b0;
        check("claim_pulse",   bus.o_claimed, 32'h0000_0200);
        check("claim_topi_id", bus.o_topi_id, 0);
        check("claim_irq",     bus.o_irq,     0);
        set_src(9, 3'd7, 1'b0);
        tick(1);
        check("claim_one_cycle", bus.o_claimed, 0);
        wait_topi(5'd5, 64);
        check("after_claim_id",   bus.o_topi_id,   5);
        check("after_claim_prio", bus.o_topi_prio, 4);

        // Spurious claim
        set_src(5, 3'd7, 1'b0);
        tick(64);
        check("spur_topi", bus.o_topi_id, 0);
        bus.i_claim = 1'b1;
        tick(1);
        bus.i_claim = 1'b0;
        check("spur_claimed0", bus.o_claimed, 0);
        tick(1);
        check("spur_claimed1", bus.o_claimed, 0);

        // Exact pass timing after reset, then claim coincident with COMMIT
        set_src(9, 3'd2, 1'b1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(31);
        check("pass_before_commit", bus.o_topi_id, 0);
        tick(1);
        check("pass_commit", bus.o_topi_id, 9);
        tick(31);
        bus.i_claim = 1'b1;
        tick(1);
        bus.i_claim = 1'b0;
        check("cc_pulse", bus.o_claimed, 32'h0000_0200);
        check("cc_topi",  bus.o_topi_id, 0);
        set_src(9, 3'd7, 1'b0);
        tick(1);
        check("cc_single", bus.o_claimed, 0);
        check("cc_topi_w", bus.o_topi_id, 0);

        // Reset mid-scan
        set_src(5, 3'd4, 1'b1);
        wait_topi(5'd5, 64);
        check("pre_rst_id", bus.o_topi_id, 5);
        tick(10);
        rst = 1'b1;
        tick(1);
        check("midrst_id",      bus.o_topi_id,   0);
        check("midrst_prio",    bus.o_topi_prio, 0);
        check("midrst_irq",     bus.o_irq,       0);
        check("midrst_claimed", bus.o_claimed,   0);
        rst = 1'b0;

        // Reset together with a claim emits no pulse
        wait_topi(5'd5, 64);
        check("pre_rstclaim_id", bus.o_topi_id, 5);
        bus.i_claim = 1'b1;
        rst         = 1'b1;
        tick(1);
        check("rstclaim_claimed", bus.o_claimed, 0);
        check("rstclaim_topi",    bus.o_topi_id, 0);
        bus.i_claim = 1'b0;
        rst         = 1'b0;
        tick(1);
        check("rstclaim_after", bus.o_claimed, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
